// File: rtl/seg7_reader.sv
// Recovers BCD digits from a 7-segment bus: debounces each pattern, decodes it,
// and presents legal digits on a valid/ready port while counting illegal patterns.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       segments_in,
   input  logic             sample_en,
   input  logic             clear_err,
   output logic [3:0]       digit_out,
   output logic             digit_valid,
   input  logic             digit_ready,
   output logic             invalid_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             overrun
);

   localparam logic [3:0] LAST_CNT = 4'(STABLE_CYCLES - 1);

   logic [6:0]       cur_q, cur_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             locked_q, locked_d;
   logic [3:0]       digit_q, digit_d;
   logic             valid_q, valid_d;
   logic             inv_q, inv_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             ovr_q, ovr_d;

   logic             accept;
   logic [5:0]       dec;
   logic             dec_legal, dec_blank;
   logic [3:0]       dec_val;

   // Returns {legal, blank, value}; anything that is not an exact match is illegal.
   function automatic logic [5:0] decode(input logic [6:0] s);
      logic [5:0] r;
      case (s)
         7'b0111111: r = {2'b10, 4'd0};
         7'b0000110: r = {2'b10, 4'd1};
         7'b1011011: r = {2'b10, 4'd2};
         7'b1001111: r = {2'b10, 4'd3};
         7'b1100110: r = {2'b10, 4'd4};
         7'b1101101: r = {2'b10, 4'd5};
         7'b1111100: r = {2'b10, 4'd6};
         7'b0000111: r = {2'b10, 4'd7};
         7'b1111111: r = {2'b10, 4'd8};
         7'b1100111: r = {2'b10, 4'd9};
         7'b0000000: r = {2'b01, 4'd0};
         default:    r = 6'b000000;
      endcase
      return r;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      logic [ERR_W-1:0] r;
      r = v;
      if (v != {ERR_W{1'b1}}) r = v + {{(ERR_W-1){1'b0}}, 1'b1};
      return r;
   endfunction

   assign dec       = decode(segments_in);
   assign dec_legal = dec[5];
   assign dec_blank = dec[4];
   assign dec_val   = dec[3:0];

   always_comb begin
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      locked_d = locked_q;
      accept   = 1'b0;
      if (sample_en) begin
         if (segments_in != cur_q) begin
            cur_d    = segments_in;
            cnt_d    = 4'd0;
            locked_d = 1'b0;
            if (STABLE_CYCLES == 1) begin
               accept   = 1'b1;
               locked_d = 1'b1;
            end
         end else if (!locked_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == LAST_CNT) begin
               accept   = 1'b1;
               locked_d = 1'b1;
            end
         end
      end
   end

   // A legal acceptance beats a same-edge consume; clear beats a same-edge increment.
   always_comb begin
      digit_d = digit_q;
      valid_d = valid_q;
      inv_d   = 1'b0;
      err_d   = err_q;
      ovr_d   = ovr_q;
      if (valid_q && digit_ready) valid_d = 1'b0;
      if (accept && dec_legal) begin
         digit_d = dec_val;
         valid_d = 1'b1;
         if (valid_q && !digit_ready) ovr_d = 1'b1;
      end else if (accept && !dec_blank) begin
         inv_d = 1'b1;
         err_d = sat_inc(err_q);
      end
      if (clear_err) begin
         err_d = '0;
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_q    <= 7'b0000000;
         cnt_q    <= 4'd0;
         locked_q <= 1'b1;
         digit_q  <= 4'd0;
         valid_q  <= 1'b0;
         inv_q    <= 1'b0;
         err_q    <= '0;
         ovr_q    <= 1'b0;
      end else begin
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         digit_q  <= digit_d;
         valid_q  <= valid_d;
         inv_q    <= inv_d;
         err_q    <= err_d;
         ovr_q    <= ovr_d;
      end
   end

   assign digit_out     = digit_q;
   assign digit_valid   = valid_q;
   assign invalid_pulse = inv_q;
   assign err_count     = err_q;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE_CYCLES=4 and ERR_W=8.
module tb_seg7_reader;

   logic       clk;
   logic       reset;
   logic [6:0] segments_in;
   logic       sample_en;
   logic       clear_err;
   logic [3:0] digit_out;
   logic       digit_valid;
   logic       digit_ready;
   logic       invalid_pulse;
   logic [7:0] err_count;
   logic       overrun;

   int n_tests;
   int n_failed;

   seg7_reader #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .segments_in  (segments_in),
      .sample_en    (sample_en),
      .clear_err    (clear_err),
      .digit_out    (digit_out),
      .digit_valid  (digit_valid),
      .digit_ready  (digit_ready),
      .invalid_pulse(invalid_pulse),
      .err_count    (err_count),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_tests     = 0;
      n_failed    = 0;
      reset       = 1'b1;
      segments_in = 7'b0;
      sample_en   = 1'b0;
      clear_err   = 1'b0;
      digit_ready = 1'b0;
      step(2);
      reset = 1'b0;
      check("rst_digit", digit_out, 0);
      check("rst_valid", digit_valid, 0);
      check("rst_inv", invalid_pulse, 0);
      check("rst_err", err_count, 0);
      check("rst_ovr", overrun, 0);

      // Digit 2 held: visible after the 4th sampled edge, single event
      sample_en   = 1'b1;
      segments_in = 7'b1011011;
      step(3);
      check("t1_valid_early", digit_valid, 0);
      step(1);
      check("t1_valid", digit_valid, 1);
      check("t1_digit", digit_out, 2);
      step(3);
      check("t1_valid_hold", digit_valid, 1);
      check("t1_digit_hold", digit_out, 2);
      digit_ready = 1'b1;
      step(1);
      digit_ready = 1'b0;
      check("t1_consumed", digit_valid, 0);
      step(3);
      check("t1_no_repeat", digit_valid, 0);

      // Short 6 discarded, then 9 delivered
      segments_in = 7'b1111100;
      step(3);
      segments_in = 7'b1100111;
      step(3);
      check("t2_no_six", digit_valid, 0);
      step(1);
      check("t2_valid", digit_valid, 1);
      check("t2_digit", digit_out, 9);
      check("t2_err", err_count, 0);
      digit_ready = 1'b1;
      step(1);
      digit_ready = 1'b0;

      // Illegal pattern: one pulse, counter increments, then saturates
      segments_in = 7'b1111110;
      step(3);
      check("t3_inv_early", invalid_pulse, 0);
      step(1);
      check("t3_inv", invalid_pulse, 1);
      check("t3_err", err_count, 1);
      check("t3_valid", digit_valid, 0);
      step(1);
      check("t3_inv_clear", invalid_pulse, 0);
      for (int i = 0; i < 300; i++) begin
         segments_in = (i % 2 == 0) ? 7'b1111101 : 7'b1111110;
         step(4);
      end
      check("t3_sat", err_count, 255);

      // Clear on the same edge as an illegal acceptance
      segments_in = 7'b1111101;
      step(3);
      clear_err = 1'b1;
      step(1);
      clear_err = 1'b0;
      check("t6_err", err_count, 0);
      check("t6_inv", invalid_pulse, 1);
      step(1);
      check("t6_inv_off", invalid_pulse, 0);
      check("t6_err_hold", err_count, 0);

      // Overrun: 3 unconsumed, then 5
      segments_in = 7'b1001111;
      step(4);
      check("t4_d3", digit_out, 3);
      segments_in = 7'b1101101;
      step(4);
      check("t4_ovr", overrun, 1);
      check("t4_d5", digit_out, 5);
      check("t4_valid", digit_valid, 1);
      clear_err = 1'b1;
      step(1);
      clear_err = 1'b0;
      check("t4_ovr_clr", overrun, 0);
      check("t4_d5_kept", digit_out, 5);
      check("t4_valid_kept", digit_valid, 1);
      segments_in = 7'b1001111;
      step(3);
      digit_ready = 1'b1;
      step(1);
      digit_ready = 1'b0;
      check("t4_ready_ovr", overrun, 0);
      check("t4_ready_valid", digit_valid, 1);
      check("t4_ready_d3", digit_out, 3);
      digit_ready = 1'b1;
      step(1);
      digit_ready = 1'b0;
      check("t4_drain", digit_valid, 0);

      // Gapped sample_en: accepted on the 4th enabled sample (edge 7)
      segments_in = 7'b0000110;
      for (int e = 1; e <= 6; e++) begin
         sample_en = (e % 2 == 1);
         step(1);
      end
      check("t5_gap_early", digit_valid, 0);
      sample_en = 1'b1;
      step(1);
      check("t5_gap_valid", digit_valid, 1);
      check("t5_gap_digit", digit_out, 1);

      // Reset mid-count discards the pending pattern
      segments_in = 7'b1011011;
      step(3);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("t5_rst_digit", digit_out, 0);
      check("t5_rst_valid", digit_valid, 0);
      check("t5_rst_err", err_count, 0);
      segments_in = 7'b0000000;
      step(5);
      check("t5_blank_valid", digit_valid, 0);
      check("t5_blank_inv", invalid_pulse, 0);
      segments_in = 7'b1011011;
      step(4);
      check("t5_post_valid", digit_valid, 1);
      check("t5_post_digit", digit_out, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
